// File: rtl/cost_table_pkg.sv
// Shared types and dimensions for the cost-table controller and its storage.
package cost_table_pkg;

   localparam int unsigned N      = 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned COST_W = 7;
   localparam int unsigned MIN_W  = 10;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned LD_W   = 2 * IDX_W;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REPORT = 2'd2
   } state_e;

endpackage

// File: rtl/cost_table_ctrl_mem.sv
// 8x8 cost register file: one synchronous write port, one asynchronous read port.
module cost_mem
   import cost_table_pkg::*;
(
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  wrow_i,
   input  logic [IDX_W-1:0]  wcol_i,
   input  logic [COST_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]  rrow_i,
   input  logic [IDX_W-1:0]  rcol_i,
   output logic [COST_W-1:0] rdata_o
);

   logic [COST_W-1:0] mem_q [N][N];

   // Contents are deliberately not reset; they survive into the next load.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wrow_i][wcol_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rrow_i][rcol_i];

endmodule

// File: rtl/cost_table_ctrl.sv
// Loads an 8x8 cost table, serves it to the assignment engine, and holds the result.
module cost_table_ctrl
   import cost_table_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [COST_W-1:0] in_data,
   input  logic              in_last,
   input  logic [IDX_W-1:0]  W,
   input  logic [IDX_W-1:0]  J,
   output logic [COST_W-1:0] Cost,
   output logic              jam_rst,
   input  logic              jam_valid,
   input  logic [MIN_W-1:0]  jam_mincost,
   input  logic [CNT_W-1:0]  jam_matchcount,
   output logic              res_valid,
   output logic [MIN_W-1:0]  res_mincost,
   output logic [CNT_W-1:0]  res_matchcount,
   input  logic              res_ack,
   output logic              err
);

   state_e            state_q, state_d;
   logic [LD_W-1:0]   cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              res_valid_q, res_valid_d;
   logic [MIN_W-1:0]  res_mincost_q, res_mincost_d;
   logic [CNT_W-1:0]  res_matchcount_q, res_matchcount_d;
   logic              accept;
   logic              cnt_full;
   logic [COST_W-1:0] mem_rdata;

   assign accept   = in_valid && (state_q == ST_LOAD);
   assign cnt_full = (cnt_q == '1);

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      err_d            = err_q;
      res_valid_d      = res_valid_q;
      res_mincost_d    = res_mincost_q;
      res_matchcount_d = res_matchcount_q;
      in_ready         = 1'b0;
      jam_rst          = 1'b1;
      unique case (state_q)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (accept) begin
               // in_last only flags framing errors; the count alone ends the load.
               if (in_last != cnt_full) begin
                  err_d = 1'b1;
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_full) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            jam_rst = 1'b0;
            if (jam_valid) begin
               state_d          = ST_REPORT;
               res_valid_d      = 1'b1;
               res_mincost_d    = jam_mincost;
               res_matchcount_d = jam_matchcount;
            end
         end
         ST_REPORT: begin
            if (res_ack) begin
               state_d     = ST_LOAD;
               res_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q          <= ST_LOAD;
         cnt_q            <= '0;
         err_q            <= 1'b0;
         res_valid_q      <= 1'b0;
         res_mincost_q    <= '0;
         res_matchcount_q <= '0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         err_q            <= err_d;
         res_valid_q      <= res_valid_d;
         res_mincost_q    <= res_mincost_d;
         res_matchcount_q <= res_matchcount_d;
      end
   end

   cost_mem u_mem (
      .clk_i   (CLK),
      .we_i    (accept && !RST),
      .wrow_i  (cnt_q[LD_W-1:IDX_W]),
      .wcol_i  (cnt_q[IDX_W-1:0]),
      .wdata_i (in_data),
      .rrow_i  (W),
      .rcol_i  (J),
      .rdata_o (mem_rdata)
   );

   assign Cost           = (state_q == ST_RUN) ? mem_rdata : '0;
   assign res_valid      = res_valid_q;
   assign res_mincost    = res_mincost_q;
   assign res_matchcount = res_matchcount_q;
   assign err            = err_q;

endmodule

// File: tb/tb_cost_table_ctrl.sv
// Directed and randomized checks of cost_table_ctrl against a behavioural table model.
module tb_cost_table_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [6:0] in_data = '0;
   logic       in_last = 1'b0;
   logic [2:0] W = '0;
   logic [2:0] J = '0;
   logic [6:0] Cost;
   logic       jam_rst;
   logic       jam_valid = 1'b0;
   logic [9:0] jam_mincost = '0;
   logic [3:0] jam_matchcount = '0;
   logic       res_valid;
   logic [9:0] res_mincost;
   logic [3:0] res_matchcount;
   logic       res_ack = 1'b0;
   logic       err;

   cost_table_ctrl dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .W(W), .J(J), .Cost(Cost), .jam_rst(jam_rst),
      .jam_valid(jam_valid), .jam_mincost(jam_mincost), .jam_matchcount(jam_matchcount),
      .res_valid(res_valid), .res_mincost(res_mincost), .res_matchcount(res_matchcount),
      .res_ack(res_ack), .err(err)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: a phase name, a count of entries loaded so far, and a flat table.
   string m_phase = "LOAD";
   int    m_loaded = 0;
   bit    m_err = 0;
   bit    m_rv = 0;
   int    m_rmc = 0;
   int    m_rmm = 0;
   int    tbl [64];
   int    runs_seen = 0;
   logic  prev_jam_rst = 1'b1;

   function automatic void model_edge();
      if (RST) begin
         m_phase = "LOAD"; m_loaded = 0; m_err = 0; m_rv = 0; m_rmc = 0; m_rmm = 0;
      end else if (m_phase == "LOAD") begin
         if (in_valid) begin
            tbl[m_loaded] = int'(in_data);
            if (in_last != (m_loaded == 63)) m_err = 1;
            m_loaded = m_loaded + 1;
            if (m_loaded == 64) begin
               m_loaded = 0;
               m_phase  = "RUN";
            end
         end
      end else if (m_phase == "RUN") begin
         if (jam_valid) begin
            m_rv = 1; m_rmc = int'(jam_mincost); m_rmm = int'(jam_matchcount);
            m_phase = "REPORT";
         end
      end else begin
         if (res_ack) begin
            m_rv = 0;
            m_phase = "LOAD";
         end
      end
   endfunction

   task automatic tick();
      int exp_cost;
      @(posedge CLK);
      #1;
      model_edge();
      W = 3'($urandom);
      J = 3'($urandom);
      #1;
      exp_cost = (m_phase == "RUN") ? tbl[int'(W) * 8 + int'(J)] : 0;
      check_eq("in_ready", in_ready, m_phase == "LOAD");
      check_eq("jam_rst", jam_rst, m_phase != "RUN");
      check_eq("cost", Cost, exp_cost);
      check_eq("res_valid", res_valid, m_rv);
      check_eq("res_mincost", res_mincost, m_rmc);
      check_eq("res_matchcount", res_matchcount, m_rmm);
      check_eq("err", err, m_err);
      if (prev_jam_rst && !jam_rst) runs_seen++;
      prev_jam_rst = jam_rst;
   endtask

   task automatic idle_inputs();
      RST = 0; in_valid = 0; in_last = 0; jam_valid = 0; res_ack = 0;
   endtask

   // Load 64 entries; gap inserts an idle cycle after each beat; bad_last marks that index.
   task automatic load_table(input int seed, input bit gap, input int last_at);
      for (int k = 0; k < 64; k++) begin
         in_valid = 1;
         in_data  = 7'((4 * (k / 8) + (k % 8) + seed) & 8'h7F);
         in_last  = (k == last_at) || (k == 63 && last_at == 63);
         tick();
         if (gap) begin
            in_valid = 0;
            in_data  = 7'h55;
            tick();
         end
      end
      in_valid = 0;
      in_last  = 0;
   endtask

   task automatic finish_report(input int mc, input int mm);
      jam_valid = 1; jam_mincost = 10'(mc); jam_matchcount = 4'(mm); res_ack = 1;
      tick();
      jam_valid = 0;
      tick();
      res_ack = 0;
   endtask

   initial begin
      int runs_before;
      RST = 1;
      tick();
      tick();
      idle_inputs();

      // Pattern load, Cost(3,5) = 4*3+5
      load_table(0, 0, 63);
      check_eq("run_after_64", in_ready, 1'b0);
      W = 3; J = 5; #1;
      check_eq("cost_3_5", Cost, 17);
      check_eq("err_clean", err, 0);
      tick();

      // Result captured while ack already held; valid lasts one cycle
      jam_valid = 1; jam_mincost = 10'd37; jam_matchcount = 4'd2; res_ack = 1;
      tick();
      check_eq("res_mc_37", res_mincost, 37);
      check_eq("res_mm_2", res_matchcount, 2);
      check_eq("res_v_hi", res_valid, 1);
      jam_valid = 0;
      tick();
      check_eq("res_v_lo", res_valid, 0);
      check_eq("res_mc_kept", res_mincost, 37);
      res_ack = 0;

      // Gapped load must equal a gap-free one
      load_table(0, 1, 63);
      W = 3; J = 5; #1;
      check_eq("gap_cost_3_5", Cost, 17);
      tick();

      // In REPORT, writes and new results are ignored until ack
      jam_valid = 1; jam_mincost = 10'd5; jam_matchcount = 4'd1;
      tick();
      in_valid = 1; in_data = 7'h7F; jam_mincost = 10'd99; jam_matchcount = 4'd9;
      repeat (4) tick();
      check_eq("report_hold", res_mincost, 5);
      in_valid = 0; jam_valid = 0; res_ack = 1;
      tick();
      res_ack = 0;

      // Early in_last on entry 10 sets sticky err; load still runs to 64
      load_table(3, 0, 10);
      check_eq("err_sticky", err, 1);
      finish_report(200, 7);
      check_eq("err_after_report", err, 1);

      // Reset mid-load discards partial data; RUN is entered exactly once
      for (int k = 0; k < 30; k++) begin
         in_valid = 1; in_data = 7'h11; tick();
      end
      RST = 1; tick(); RST = 0;
      check_eq("err_cleared", err, 0);
      runs_before = runs_seen;
      load_table(9, 0, 63);
      tick();
      check_eq("run_once", runs_seen - runs_before, 1);
      W = 0; J = 0; #1;
      check_eq("entry_0_0", Cost, 9);
      finish_report(1, 1);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         RST       = ($urandom_range(0, 199) == 0);
         in_valid  = $urandom_range(0, 1);
         in_data   = 7'($urandom);
         in_last   = (m_loaded == 63) ^ ($urandom_range(0, 29) == 0);
         jam_valid = ($urandom_range(0, 19) == 0);
         jam_mincost    = 10'($urandom);
         jam_matchcount = 4'($urandom);
         res_ack   = ($urandom_range(0, 2) == 0);
         tick();
      end
      idle_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cost_table_ctrl.md
COST_TABLE_CTRL -- requirements
Module: cost_table_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port in_valid  input  1  cost entry offered.
REQ-004 SHALL have port in_ready  output  1  entry accepted when in_valid&in_ready at rising edge.
REQ-005 SHALL have port in_data  input  7  cost value, row-major (worker-major) order.
REQ-006 SHALL have port in_last  input  1  marks 64th entry.
REQ-007 SHALL have port W  input  3  worker index from the assignment engine.
REQ-008 SHALL have port J  input  3  job index from the assignment engine.
REQ-009 SHALL have port Cost  output  7  cost of (W,J).
REQ-010 SHALL have port jam_rst  output  1  reset to the assignment engine.
REQ-011 SHALL have port jam_valid  input  1  engine result ready.
REQ-012 SHALL have port jam_mincost  input  10  engine minimum cost.
REQ-013 SHALL have port jam_matchcount  input  4  engine count of minimum-cost assignments.
REQ-014 SHALL have port res_valid  output  1  result held for the consumer.
REQ-015 SHALL have port res_mincost  output  10  captured minimum cost.
REQ-016 SHALL have port res_matchcount  output  4  captured match count.
REQ-017 SHALL have port res_ack  input  1  consumer accepts result.
REQ-018 SHALL have port err  output  1  sticky framing error.

Function
REQ-019 SHALL implement FSM states LOAD, RUN, REPORT; reset state LOAD.
REQ-020 LOAD: in_ready=1, jam_rst=1; each accept writes in_data to entry (cnt[5:3],cnt[2:0]) and increments 6-bit cnt.
REQ-021 LOAD -> RUN on the accept with cnt=63; cnt wraps to 0.
REQ-022 in_last=1 on accept with cnt!=63, or in_last=0 on accept with cnt=63, SHALL set err; transition governed only by cnt.
REQ-023 RUN: in_ready=0, jam_rst=0; Cost SHALL be combinational read of entry (W,J), zero added latency (engine samples mid-cycle).
REQ-024 In LOAD and REPORT, Cost SHALL be 0.
REQ-025 RUN -> REPORT on jam_valid=1; same edge captures jam_mincost/jam_matchcount into res_*, sets res_valid=1.
REQ-026 REPORT: jam_rst=1, in_ready=0, res_* held stable; on res_ack=1 -> LOAD, res_valid=0, res_* retained.
REQ-027 res_ack SHALL be ignored outside REPORT, including the edge that enters REPORT.
REQ-028 in_valid outside LOAD SHALL be ignored, no table write.
REQ-029 Table contents SHALL persist from RUN into the next LOAD until overwritten.
REQ-030 jam_valid outside RUN SHALL be ignored.

Reset
REQ-031 RST=1 at a rising edge SHALL set: state LOAD, cnt 0, err 0, res_valid 0, res_mincost 0, res_matchcount 0; outputs thus in_ready=1, jam_rst=1, Cost=0.
REQ-032 Reset mid-LOAD discards the partial load; next accept writes entry (0,0).
REQ-033 Reset in RUN/REPORT drops any pending result; table memory not cleared.
REQ-034 RST SHALL dominate all other inputs in the same cycle.

Structure
REQ-035 Shared package cost_table_pkg SHALL hold the state enum and constants N=8, IDX_W=3, COST_W=7, MIN_W=10, CNT_W=4.
REQ-036 Storage SHALL be sub-module cost_mem: 8x8x7 register file, one synchronous write port, one asynchronous read port; no reset on contents.
REQ-037 FSM, cnt, err, result registers SHALL live in cost_table_ctrl.

Verification
REQ-038 Load 64 entries value=(4*row+col)&7'h7F, in_last on 64th -> in_ready falls after 64th accept, jam_rst=0, W=3,J=5 gives Cost=17, err=0.
REQ-039 in_valid toggled 1/0 every cycle during load -> exactly 64 accepts before RUN, table identical to gap-free load.
REQ-040 in_last on entry 10 -> err=1 after that edge, load continues to 64 entries, err stays 1 until RST.
REQ-041 In RUN, jam_valid=1 with mincost=10'd37, matchcount=4'd2, res_ack held 1 -> res_valid=1 for exactly one cycle, res_mincost=37, res_matchcount=2, then LOAD.
REQ-042 RST after 30 accepts -> cnt=0, next 64 accepts produce full table, RUN entered exactly once.
REQ-043 In REPORT, in_valid=1 and jam_valid=1 with new values -> no table write, res_* unchanged until res_ack.
